// File: rtl/imem_loader_pkg.sv
// ============================================================================
// imem_loader_pkg : shared types and constants for the boot-time loader
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CKSUM  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam int         HDR_BYTES      = 2;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] CK_GOOD        = 8'h00;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
// byte_packer : MSB-first byte-to-word packer with a one-cycle word strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q,   cnt_d;
    logic [23:0] shift_q, shift_d;

    // The 4th byte completes the word combinationally so the top can register it.
    assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {shift_q, byte_i};

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : framed byte-stream loader for instruction memory; holds the
//               core in reset until a checksum-verified image is written
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        n_hi_q;
    logic [15:0]       n_q;
    logic [ADDR_W:0]   idx_q;
    logic [7:0]        sum_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic [7:0]        sum_next;
    logic [15:0]       n_hdr;
    logic              last_word;
    logic              word_valid;
    logic [31:0]       word;

    assign accept    = in_valid && in_ready;
    assign sum_next  = sum_q + in_data;
    assign n_hdr     = {n_hi_q, in_data};
    // Compare at 17 bits so N == DEPTH works with the ADDR_W+1 bit index.
    assign last_word = (17'(idx_q) + 17'd1) == {1'b0, n_q};

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (accept && (state_q == ST_DATA)),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_HDR_HI;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            ST_HDR_HI: begin
                in_ready = 1'b1;
                if (accept) state_d = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                in_ready = 1'b1;
                if (accept) begin
                    if ({1'b0, n_hdr} > 17'(DEPTH)) state_d = ST_ERR;
                    else if (n_hdr == 16'd0)        state_d = ST_CKSUM;
                    else                            state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (word_valid && last_word) state_d = ST_CKSUM;
            end
            ST_CKSUM: begin
                in_ready = 1'b1;
                if (accept) state_d = (sum_next == CK_GOOD) ? ST_RUN : ST_ERR;
            end
            ST_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_hi_q  <= 8'd0;
            n_q     <= 16'd0;
            idx_q   <= '0;
            sum_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            we_q <= word_valid;
            if (accept) sum_q <= sum_next;
            if (accept && (state_q == ST_HDR_HI)) n_hi_q <= in_data;
            if (accept && (state_q == ST_HDR_LO)) begin
                n_q   <= n_hdr;
                idx_q <= '0;
            end else if (word_valid) begin
                idx_q <= idx_q + 1'b1;
            end
            if (word_valid) begin
                addr_q  <= idx_q[ADDR_W-1:0];
                wdata_q <= word;
            end
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed, table-driven bench for imem_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int checks   = 0;
    int failures = 0;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    bit          watch_cpu   = 1'b0;
    bit          cpu_dropped = 1'b0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr.push_back(int'(im_addr));
            wr_data.push_back(im_wdata);
        end
        if (watch_cpu && cpu_rst !== 1'b1) cpu_dropped = 1'b1;
    end

    typedef struct {
        string       name;
        logic [87:0] bytes;
        int          len;
        bit          gaps;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        done_e;
        logic        err_e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bytes are packed first-byte-first from bit 87 downward.
    task automatic send(input logic [87:0] b, input int first, input int len, input bit gaps);
        for (int i = first; i < first + len; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ((i % 3 == 1) ? 2 : ((i % 4 == 0) ? 1 : 0)) @(posedge clk);
                #1;
            end
            send_byte(b[87 - 8*i -: 8]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rst in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " rst im_we"},    32'(im_we),    32'd0);
        chk({tag, " rst im_addr"},  32'(im_addr),  32'd0);
        chk({tag, " rst im_wdata"}, im_wdata,      32'd0);
        chk({tag, " rst cpu_rst"},  32'(cpu_rst),  32'd1);
        chk({tag, " rst done"},     32'(done),     32'd0);
        chk({tag, " rst err"},      32'(err),      32'd0);
    endtask

    localparam logic [87:0] FRAME1 = 88'h0002200800052009000A9E;

    vec_t vecs[6];

    initial begin
        logic [7:0]  sum;
        logic [31:0] w;
        int          bad;
        int          nbefore;

        vecs[0] = '{"good2",   FRAME1,                         11, 1'b0, 2, 32'h20080005, 32'h2009000A, 1'b1, 1'b0};
        vecs[1] = '{"badck",   88'h0002200800052009000A9F,     11, 1'b0, 2, 32'h20080005, 32'h2009000A, 1'b0, 1'b1};
        vecs[2] = '{"gapped",  FRAME1,                         11, 1'b1, 2, 32'h20080005, 32'h2009000A, 1'b1, 1'b0};
        vecs[3] = '{"empty",   {24'h000000, 64'h0},             3, 1'b0, 0, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[4] = '{"oversz",  {16'h0401, 72'h0},               2, 1'b0, 0, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[5] = '{"oneword", {56'h0001DEADBEEFC7, 32'h0},     7, 1'b0, 1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            chk_reset_vals(vecs[v].name);
            send(vecs[v].bytes, 0, vecs[v].len, vecs[v].gaps);
            // Sampled 1 time unit after the edge that accepted the last byte.
            chk({vecs[v].name, " done"},     32'(done),     32'(vecs[v].done_e));
            chk({vecs[v].name, " err"},      32'(err),      32'(vecs[v].err_e));
            chk({vecs[v].name, " cpu_rst"},  32'(cpu_rst),  32'(!vecs[v].done_e));
            chk({vecs[v].name, " in_ready"}, 32'(in_ready), 32'd0);
            chk({vecs[v].name, " nwrites"},  32'(wr_addr.size()), 32'(vecs[v].nwr));
            for (int k = 0; k < vecs[v].nwr && k < wr_addr.size(); k++) begin
                chk({vecs[v].name, " waddr"}, 32'(wr_addr[k]), 32'(k));
                chk({vecs[v].name, " wdata"}, wr_data[k], (k == 0) ? vecs[v].w0 : vecs[v].w1);
            end
        end

        // Empty image: RUN only on the third byte.
        do_reset();
        send({24'h000000, 64'h0}, 0, 2, 1'b0);
        chk("empty early done", 32'(done), 32'd0);
        send({24'h000000, 64'h0}, 2, 1, 1'b0);
        chk("empty third done", 32'(done), 32'd1);

        // Oversize header: no error before N_LO.
        do_reset();
        send({16'h0401, 72'h0}, 0, 1, 1'b0);
        chk("oversz early err", 32'(err), 32'd0);

        // Reset mid-frame, including a byte presented with rst high.
        do_reset();
        watch_cpu   = 1'b1;
        cpu_dropped = 1'b0;
        send(FRAME1, 0, 5, 1'b0);
        chk("midrst writes before", 32'(wr_addr.size()), 32'd0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_reset_vals("midrst");
        send(FRAME1, 0, 10, 1'b0);
        watch_cpu = 1'b0;
        chk("midrst cpu_rst held", 32'(cpu_dropped), 32'd0);
        send(FRAME1, 10, 1, 1'b0);
        chk("midrst done", 32'(done), 32'd1);
        chk("midrst nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("midrst addr0", 32'(wr_addr[0]), 32'd0);
            chk("midrst data0", wr_data[0], 32'h20080005);
            chk("midrst addr1", 32'(wr_addr[1]), 32'd1);
            chk("midrst data1", wr_data[1], 32'h2009000A);
        end
        nbefore  = wr_addr.size();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("postrun in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("postrun nwrites", 32'(wr_addr.size()), 32'(nbefore));
        chk("postrun done", 32'(done), 32'd1);
        chk("postrun err",  32'(err),  32'd0);

        // Full-depth image: N == DEPTH is legal and lands at 0..DEPTH-1.
        do_reset();
        sum = 8'h00;
        send_byte(8'(DEPTH >> 8));
        sum = sum + 8'(DEPTH >> 8);
        send_byte(8'(DEPTH));
        sum = sum + 8'(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            w = (32'(i) * 32'h00010001) ^ 32'hA5A50000;
            for (int j = 3; j >= 0; j--) begin
                send_byte(w[8*j +: 8]);
                sum = sum + w[8*j +: 8];
            end
        end
        send_byte(8'h00 - sum);
        chk("full done", 32'(done), 32'd1);
        chk("full nwrites", 32'(wr_addr.size()), 32'(DEPTH));
        bad = 0;
        for (int k = 0; k < wr_addr.size(); k++) begin
            w = (32'(k) * 32'h00010001) ^ 32'hA5A50000;
            if (wr_addr[k] != k || wr_data[k] !== w) bad++;
        end
        chk("full word errors", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
